// File: rtl/ps2_key_event_ctrl_if.sv
// Byte-in / key-event-out bundle between the PS/2 receiver, this controller
// and its consumer. The slave modport is the controller side.
interface ps2_key_event_ctrl_if #(
   parameter int CNT_W = 8
);
   logic [7:0]       rx_data;
   logic             rx_valid;
   logic [7:0]       ev_code;
   logic             ev_ext;
   logic             ev_break;
   logic             ev_valid;
   logic             ev_ready;
   logic             key_held;
   logic [7:0]       held_code;
   logic             held_ext;
   logic             segs_enable;
   logic [CNT_W-1:0] press_cnt;
   logic             ovf;
   logic             clr_ovf;

   modport master (
      output rx_data, rx_valid, ev_ready, clr_ovf,
      input  ev_code, ev_ext, ev_break, ev_valid, key_held, held_code,
             held_ext, segs_enable, press_cnt, ovf
   );

   modport slave (
      input  rx_data, rx_valid, ev_ready, clr_ovf,
      output ev_code, ev_ext, ev_break, ev_valid, key_held, held_code,
             held_ext, segs_enable, press_cnt, ovf
   );
endinterface

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 scan-code sequencer: E0/F0 prefix parsing, typematic-repeat filter,
// held-key tracking and a first-word-fall-through event FIFO.
module ps2_key_event_ctrl #(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   ps2_key_event_ctrl_if.slave  bus
);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

   state_t state_reg, state_next;

   logic       ev_form, ev_ext_c, ev_brk_c;
   logic       is_repeat, push, pop, full, wr_en, drop;
   logic       held_match;

   logic [9:0]       mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic [9:0]       head, last_reg;

   logic             key_held_reg;
   logic [7:0]       held_code_reg;
   logic             held_ext_reg;
   logic [CNT_W-1:0] press_cnt_reg;
   logic             ovf_reg;

   // Parser state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Parser next state
   always_comb begin
      state_next = state_reg;
      if (bus.rx_valid) begin
         case (bus.rx_data)
            8'hE0: state_next = GOT_E0;
            8'hF0: begin
               if (state_reg == IDLE)        state_next = GOT_F0;
               else if (state_reg == GOT_E0) state_next = GOT_E0F0;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Parser outputs: an event forms on any non-prefix, non-error byte
   always_comb begin
      ev_form  = 1'b0;
      ev_ext_c = (state_reg == GOT_E0) || (state_reg == GOT_E0F0);
      ev_brk_c = (state_reg == GOT_F0) || (state_reg == GOT_E0F0);
      if (bus.rx_valid && bus.rx_data != 8'hE0 && bus.rx_data != 8'hF0 &&
          bus.rx_data != 8'h00 && bus.rx_data != 8'hFF)
         ev_form = 1'b1;
   end

   assign held_match = key_held_reg && (held_ext_reg == ev_ext_c) &&
                       (held_code_reg == bus.rx_data);
   assign is_repeat  = ev_form && !ev_brk_c && held_match;
   assign push       = ev_form && !is_repeat;
   assign pop        = bus.ev_valid && bus.ev_ready;
   assign full       = (count_reg == (AW+1)'(FIFO_DEPTH));
   // A pop in the same cycle frees a slot, so a full FIFO still accepts
   assign wr_en      = push && (!full || pop);
   assign drop       = push && full && !pop;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_reg] <= {ev_ext_c, ev_brk_c, bus.rx_data};
   end

   assign head = mem[rd_ptr_reg];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         last_reg   <= '0;
      end else begin
         if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
            last_reg   <= head;
         end
         case ({wr_en, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Held-key tracking counts accepted makes even when the FIFO drops them
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_held_reg  <= 1'b0;
         held_code_reg <= 8'h00;
         held_ext_reg  <= 1'b0;
         press_cnt_reg <= '0;
         ovf_reg       <= 1'b0;
      end else begin
         if (push && !ev_brk_c) begin
            key_held_reg  <= 1'b1;
            held_code_reg <= bus.rx_data;
            held_ext_reg  <= ev_ext_c;
            press_cnt_reg <= press_cnt_reg + CNT_W'(1);
         end else if (push && ev_brk_c && held_match) begin
            key_held_reg <= 1'b0;
         end
         if (drop)             ovf_reg <= 1'b1;
         else if (bus.clr_ovf) ovf_reg <= 1'b0;
      end
   end

   assign bus.ev_valid    = (count_reg != '0);
   assign bus.ev_code     = bus.ev_valid ? head[7:0] : last_reg[7:0];
   assign bus.ev_break    = bus.ev_valid ? head[8]   : last_reg[8];
   assign bus.ev_ext      = bus.ev_valid ? head[9]   : last_reg[9];
   assign bus.key_held    = key_held_reg;
   assign bus.held_code   = held_code_reg;
   assign bus.held_ext    = held_ext_reg;
   assign bus.segs_enable = key_held_reg;
   assign bus.press_cnt   = press_cnt_reg;
   assign bus.ovf         = ovf_reg;
endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed bench: stimulus pushes expected events to a queue, a monitor
// pops and compares on every handshake; status outputs are checked inline.
module tb_ps2_key_event_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ps2_key_event_ctrl_if #(.CNT_W(8)) bus ();

   ps2_key_event_ctrl #(.FIFO_DEPTH(8), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   logic [9:0] exp_q [$];
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, req);
   endtask

   // Monitor: a handshake seen at the negedge completes at the next posedge
   always @(negedge clk) begin
      if (!rst && bus.ev_valid === 1'b1 && bus.ev_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_event", {22'd0, bus.ev_ext, bus.ev_break, bus.ev_code}, 32'hFFFF);
         end else begin
            logic [9:0] e;
            e = exp_q.pop_front();
            check("event", {22'd0, bus.ev_ext, bus.ev_break, bus.ev_code}, {22'd0, e});
            $display("event code=%02h ext=%0d brk=%0d", bus.ev_code, bus.ev_ext, bus.ev_break);
         end
      end
   end

   task automatic send(input logic [7:0] b);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic expect_ev(input logic [7:0] code, input logic ext, input logic brk);
      exp_q.push_back({ext, brk, code});
   endtask

   task automatic wait_drain();
      int k;
      for (k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
      #1;
      check("drain_timeout", exp_q.size(), 0);
   endtask

   logic [7:0] codes [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};

   initial begin
      bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.ev_ready = 1'b1; bus.clr_ovf = 1'b0;
      #1;
      check("rst_ev_valid", bus.ev_valid, 0);
      check("rst_ev_fields", {bus.ev_ext, bus.ev_break, bus.ev_code}, 0);
      check("rst_held", {bus.key_held, bus.held_ext, bus.held_code, bus.segs_enable}, 0);
      check("rst_cnt_ovf", {bus.press_cnt, bus.ovf}, 0);
      @(posedge clk); #1; rst = 1'b0;

      // Make then break
      expect_ev(8'h1C, 0, 0); send(8'h1C);
      check("t1_held", {bus.key_held, bus.segs_enable}, 2'b11);
      check("t1_cnt", bus.press_cnt, 1);
      send(8'hF0); expect_ev(8'h1C, 0, 1); send(8'h1C);
      check("t1_release", {bus.key_held, bus.segs_enable}, 2'b00);
      wait_drain();

      // Typematic repeats suppressed
      expect_ev(8'h1C, 0, 0); send(8'h1C); send(8'h1C); send(8'h1C);
      check("t2_cnt", bus.press_cnt, 2);
      send(8'hF0); expect_ev(8'h1C, 0, 1); send(8'h1C);
      wait_drain();

      // Extended key
      send(8'hE0); expect_ev(8'h75, 1, 0); send(8'h75);
      check("t3_held", {bus.key_held, bus.held_ext, bus.held_code}, {2'b11, 8'h75});
      send(8'hE0); send(8'hF0); expect_ev(8'h75, 1, 1); send(8'h75);
      check("t3_release", {bus.key_held, bus.held_ext}, 2'b01);
      check("t3_cnt", bus.press_cnt, 3);
      wait_drain();

      // Overflow: 9 makes into an 8-deep FIFO with the consumer stalled
      bus.ev_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (i < 8) expect_ev(codes[i], 0, 0);
         send(codes[i]);
      end
      check("t4_valid_ovf", {bus.ev_valid, bus.ovf}, 2'b11);
      check("t4_cnt", bus.press_cnt, 12);
      bus.clr_ovf = 1'b1; @(posedge clk); #1; bus.clr_ovf = 1'b0;
      check("t4_clr_ovf", bus.ovf, 0);

      // Full FIFO: push and pop together, nothing dropped
      expect_ev(8'h4D, 0, 0);
      bus.ev_ready = 1'b1; bus.rx_data = 8'h4D; bus.rx_valid = 1'b1;
      @(posedge clk); #1;
      bus.ev_ready = 1'b0; bus.rx_valid = 1'b0;
      check("t5_no_drop", bus.ovf, 0);
      send(8'h4B);   // still full: dropped
      check("t5_still_full", bus.ovf, 1);
      check("t5_cnt", bus.press_cnt, 14);
      bus.ev_ready = 1'b1;
      wait_drain();
      repeat (2) @(posedge clk); #1;
      check("t5_empty", bus.ev_valid, 0);
      bus.clr_ovf = 1'b1; @(posedge clk); #1; bus.clr_ovf = 1'b0;

      // Reset mid-sequence discards the F0 prefix
      send(8'hF0);
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
      check("t6_after_rst", {bus.ev_valid, bus.press_cnt, bus.key_held, bus.ovf}, 0);
      expect_ev(8'h1C, 0, 0); send(8'h1C);
      check("t6_cnt", bus.press_cnt, 1);
      wait_drain();

      // Repeated F0, then error code 00
      send(8'hF0); send(8'hF0); expect_ev(8'h2A, 0, 1); send(8'h2A);
      check("t7_other_break", {bus.key_held, bus.held_code}, {1'b1, 8'h1C});
      send(8'h00);
      send(8'hF0); send(8'h00); expect_ev(8'h2B, 0, 0); send(8'h2B);
      send(8'hE0); send(8'hF0); send(8'hE0); expect_ev(8'h5A, 1, 0); send(8'h5A);
      check("t7_cnt", bus.press_cnt, 3);
      wait_drain();
      repeat (5) @(posedge clk); #1;
      check("final_empty", bus.ev_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
